// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to instruction
// memory, and holds the fetched word in a single slot. Redirects flush wrong-path work.
module fetch_unit #(
   parameter int unsigned           DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  PCSrc,
   input  logic [DATA_WIDTH-1:0] PCTarget,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [DATA_WIDTH-1:0] Instr,
   output logic [DATA_WIDTH-1:0] PC,
   output logic [DATA_WIDTH-1:0] PCPlus4
);

   typedef enum logic [1:0] {
      REQ,
      WAIT,
      WAIT_KILL
   } state_t;

   localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);
   localparam logic [DATA_WIDTH-1:0] NOP        = DATA_WIDTH'(32'h0000_0013);
   localparam logic [DATA_WIDTH-1:0] STEP       = DATA_WIDTH'(4);

   state_t                  state;
   state_t                  state_next;
   logic [DATA_WIDTH-1:0]   fpc;
   logic [DATA_WIDTH-1:0]   req_pc;
   logic                    granted;
   logic                    transfer;
   logic                    fill;

   assign imem_addr = fpc;
   assign imem_req  = (state == REQ) && (!instr_valid || instr_ready);
   assign granted   = imem_req && imem_gnt;
   assign transfer  = instr_valid && instr_ready;
   // A response only lands in the slot if it is not wrong-path and not overtaken by a redirect.
   assign fill      = (state == WAIT) && imem_rvalid && !PCSrc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= REQ;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         REQ: begin
            if (granted) begin
               state_next = PCSrc ? WAIT_KILL : WAIT;
            end
         end
         WAIT, WAIT_KILL: begin
            if (imem_rvalid) begin
               state_next = REQ;
            end else if (PCSrc) begin
               state_next = WAIT_KILL;
            end
         end
         default: state_next = REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fpc         <= RESET_PC & ALIGN_MASK;
         req_pc      <= '0;
         instr_valid <= 1'b0;
         Instr       <= NOP;
         PC          <= '0;
         PCPlus4     <= '0;
      end else begin
         if (PCSrc) begin
            fpc <= PCTarget & ALIGN_MASK;
         end else if (granted) begin
            fpc <= fpc + STEP;
         end

         if (granted) begin
            req_pc <= fpc;
         end

         // Fill takes precedence over a same-cycle drain; a redirect always empties the slot.
         if (fill) begin
            instr_valid <= 1'b1;
            Instr       <= imem_rdata;
            PC          <= req_pc;
            PCPlus4     <= req_pc + STEP;
         end else if (PCSrc || transfer) begin
            instr_valid <= 1'b0;
         end
      end
   end

endmodule
